multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multicycle sequencer for the ARM-subset core; replaces single-cycle control when IMEM/DMEM share one memory.
//  Decodes op/funct/rd, owns the NZCV flag register and condition check, and drives per-state datapath selects/enables.
//  Sits between instruction register and datapath; one instruction = 3..5 cycles.
// PARAMETERS
//  FLAGS_INIT   4'b0000  reset value of NZCV flag register {N,Z,C,V}
// PORTS
//  clk          in   1  clock, all state on rising edge
//  reset        in   1  asynchronous, active-low reset
//  op           in   2  instr[27:26]: 00 data-proc, 01 mem, 10 branch, 11 undefined
//  funct        in   6  instr[25:20]: [5]=I, [4:1]=cmd, [0]=S (mem: [0]=L)
//  rd           in   4  instr[15:12]
//  cond         in   4  instr[31:28]
//  alu_flags    in   4  ALU {N,Z,C,V} of current cycle
//  mem_ready    in   1  memory completes access this cycle (only with MEM_WAIT_EN)
//  pc_write     out  1  PC register enable
//  ir_write     out  1  instruction register enable
//  adr_src      out  1  0=PC, 1=ALU result register as memory address
//  mem_write    out  1  memory write strobe
//  reg_write    out  1  register file write enable
//  result_src   out  2  00=ALU reg, 01=read data, 10=ALU direct
//  alu_src_a    out  1  0=register A, 1=PC
//  alu_src_b    out  2  00=register B, 01=extended imm, 10=constant 4
//  alu_control  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
//  imm_src      out  2  = op (00 imm8, 01 imm12, 10 imm24)
//  reg_src      out  2  [0]=branch (Rn<-R15), [1]=mem store (Rm<-Rd)
//  state        out  4  current state encoding (debug)
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXECR=6 EXECI=7 ALUWB=8 BRANCH=9; 10..15 illegal -> FETCH.
//  FETCH->DECODE. DECODE: op00&~I->EXECR, op00&I->EXECI, op01->MEMADR, op10->BRANCH, op11->FETCH.
//  MEMADR: L->MEMRD else MEMWR. MEMRD->MEMWB. MEMWB, MEMWR, ALUWB, BRANCH->FETCH. EXECR/EXECI->ALUWB.
//  Per state (unlisted = 0, alu_control ADD):
//   FETCH: adr_src0 ir_write alu_src_a1 alu_src_b10 result_src10 next_pc.  DECODE: alu_src_a1 alu_src_b10 result_src10.
//   MEMADR: alu_src_b01.  MEMRD: adr_src1.  MEMWB: result_src01 reg_w.  MEMWR: adr_src1 mem_w.
//   EXECR: alu_src_b00 alu_op.  EXECI: alu_src_b01 alu_op.  ALUWB: result_src00 reg_w.  BRANCH: alu_src_b01 result_src10 branch.
//  alu_op decode of cmd: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB, no_write, flag_w=11); others ADD.
//  flag_w = alu_op&S: ADD/SUB -> 2'b11 (NZ+CV), AND/ORR -> 2'b10 (NZ only).
//  cond_ex from registered flags: EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V, HI C&~Z, LS ~C|Z,
//   GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V), AL 1, 1111 -> 0.
//  Gating: reg_write=reg_w&cond_ex&~no_write; mem_write=mem_w&cond_ex; pcs=branch|(reg_w&rd==4'hF);
//   pc_write=next_pc|(pcs&cond_ex&~no_write). Failed cond: sequence still walks all states, no architectural writes.
//  Flags: on edge leaving EXECR/EXECI, if cond_ex: flag_w[1] loads N,Z; flag_w[0] loads C,V (same-cycle alu_flags).
//  Reset (reset=0, async): state=FETCH, flags=FLAGS_INIT; pc_write, ir_write, mem_write, reg_write forced 0 while asserted.
//  Reset mid-instruction aborts it; first FETCH follows the first clock edge after release.
// CONFIGURATION
//  MEM_WAIT_EN defined: mem_ready port exists; FETCH, MEMRD, MEMWR hold until mem_ready=1.
//   ir_write/next_pc asserted only in FETCH cycle with mem_ready=1; mem_write held every MEMWR cycle (cond_ex gated).
//  MEM_WAIT_EN undefined: no mem_ready port; behaves as mem_ready=1 (fixed latency).
// TESTING
//  ADD R1,R2,R3 (op00,funct 001000,cond 1110): states 0,1,6,8,0; reg_write=1 only in state 8; alu_control=00 in 6.
//  SUBS imm producing zero (funct 100101) then BEQ: Z=1 latched after EXECI; branch: pc_write=1 in BRANCH.
//  BNE with Z=1: states 0,1,9,0; pc_write=0 in BRANCH; flags unchanged.
//  LDR (funct 011001): states 0,1,2,3,4; adr_src=1 in 3; result_src=01 & reg_write=1 in 4. STR: mem_write=1 in 5 only.
//  CMP R1,R2 (cmd1010,S=1): reg_write=0 in ALUWB, flags NZCV updated; ADD with rd=15: pc_write=1 in ALUWB.
//  reset=0 during MEMWR: mem_write drops immediately, state=0; MEM_WAIT_EN: mem_ready=0 3 cycles in FETCH -> ir_write only on 4th.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle sequencer (master) and the datapath/IR side (slave).
// MEM_WAIT_EN adds the mem_ready handshake input.
interface multicycle_control_if;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cond;
    logic [3:0] alu_flags;
`ifdef MEM_WAIT_EN
    logic       mem_ready;
`endif
    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_control;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [3:0] state;

    modport master (
        input  op, funct, rd, cond, alu_flags,
`ifdef MEM_WAIT_EN
        input  mem_ready,
`endif
        output pc_write, ir_write, adr_src, mem_write, reg_write, result_src,
               alu_src_a, alu_src_b, alu_control, imm_src, reg_src, state
    );

    modport slave (
        output op, funct, rd, cond, alu_flags,
`ifdef MEM_WAIT_EN
        output mem_ready,
`endif
        input  pc_write, ir_write, adr_src, mem_write, reg_write, result_src,
               alu_src_a, alu_src_b, alu_control, imm_src, reg_src, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle sequencer for the ARM-subset core: FSM, NZCV flags, condition check, datapath selects.
// Optional MEM_WAIT_EN: FETCH/MEMRD/MEMWR stall until mem_ready.
module multicycle_control #(
    parameter logic [3:0] FLAGS_INIT = 4'b0000
) (
    input logic               clk,
    input logic               reset,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD  = 4'd3, MEMWB = 4'd4,
        MEMWR  = 4'd5, EXECR  = 4'd6, EXECI  = 4'd7, ALUWB  = 4'd8, BRANCH = 4'd9
    } state_t;

    typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_ORR = 2'b11} alu_t;

    typedef struct packed {
        logic       fetch;
        logic       adr_src;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_control;
    } ctl_t;

    state_t     state, state_next;
    ctl_t       ctl_q;
    logic [3:0] flags;
    alu_t       alu_op;
    logic [1:0] flag_w;
    logic       no_write;
    logic       cond_ex;
    logic       mem_ready;
    logic       pcs;

`ifdef MEM_WAIT_EN
    assign mem_ready = bus.mem_ready;
`else
    assign mem_ready = 1'b1;
`endif

    // Per-state datapath controls, registered on entry to the state.
    function automatic ctl_t ctl_for(input state_t s, input alu_t op_sel);
        ctl_t c;
        c = '0;
        case (s)
            FETCH:   begin c.fetch = 1'b1; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; end
            DECODE:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; end
            MEMADR:  c.alu_src_b = 2'b01;
            MEMRD:   c.adr_src = 1'b1;
            MEMWB:   begin c.result_src = 2'b01; c.reg_w = 1'b1; end
            MEMWR:   begin c.adr_src = 1'b1; c.mem_w = 1'b1; end
            EXECR:   c.alu_control = op_sel;
            EXECI:   begin c.alu_src_b = 2'b01; c.alu_control = op_sel; end
            ALUWB:   c.reg_w = 1'b1;
            BRANCH:  begin c.alu_src_b = 2'b01; c.result_src = 2'b10; c.branch = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        alu_op   = ALU_ADD;
        no_write = 1'b0;
        flag_w   = 2'b00;
        case (bus.funct[4:1])
            4'b0100: alu_op = ALU_ADD;
            4'b0010: alu_op = ALU_SUB;
            4'b0000: alu_op = ALU_AND;
            4'b1100: alu_op = ALU_ORR;
            4'b1010: alu_op = ALU_SUB;
            default: alu_op = ALU_ADD;
        endcase
        if (bus.funct[0])
            flag_w = (alu_op == ALU_AND || alu_op == ALU_ORR) ? 2'b10 : 2'b11;
        if (bus.op == 2'b00 && bus.funct[4:1] == 4'b1010) begin
            no_write = 1'b1;
            flag_w   = 2'b11;
        end
    end

    always_comb begin
        cond_ex = 1'b0;
        case (bus.cond)
            4'h0: cond_ex = flags[2];
            4'h1: cond_ex = ~flags[2];
            4'h2: cond_ex = flags[1];
            4'h3: cond_ex = ~flags[1];
            4'h4: cond_ex = flags[3];
            4'h5: cond_ex = ~flags[3];
            4'h6: cond_ex = flags[0];
            4'h7: cond_ex = ~flags[0];
            4'h8: cond_ex = flags[1] & ~flags[2];
            4'h9: cond_ex = ~flags[1] | flags[2];
            4'hA: cond_ex = (flags[3] == flags[0]);
            4'hB: cond_ex = (flags[3] != flags[0]);
            4'hC: cond_ex = ~flags[2] & (flags[3] == flags[0]);
            4'hD: cond_ex = flags[2] | (flags[3] != flags[0]);
            4'hE: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // FETCH only advances once its controls are live, so the first fetch after reset takes a full cycle.
    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:   state_next = (ctl_q.fetch && mem_ready) ? DECODE : FETCH;
            DECODE: begin
                case (bus.op)
                    2'b00:   state_next = bus.funct[5] ? EXECI : EXECR;
                    2'b01:   state_next = MEMADR;
                    2'b10:   state_next = BRANCH;
                    default: state_next = FETCH;
                endcase
            end
            MEMADR:  state_next = bus.funct[0] ? MEMRD : MEMWR;
            MEMRD:   state_next = mem_ready ? MEMWB : MEMRD;
            MEMWR:   state_next = mem_ready ? FETCH : MEMWR;
            EXECR:   state_next = ALUWB;
            EXECI:   state_next = ALUWB;
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            flags <= FLAGS_INIT;
            ctl_q <= '0;
        end else begin
            state <= state_next;
            ctl_q <= ctl_for(state_next, alu_op);
            if ((state == EXECR || state == EXECI) && cond_ex) begin
                if (flag_w[1]) flags[3:2] <= bus.alu_flags[3:2];
                if (flag_w[0]) flags[1:0] <= bus.alu_flags[1:0];
            end
        end
    end

    assign pcs             = ctl_q.branch | (ctl_q.reg_w & (bus.rd == 4'hF));
    assign bus.ir_write    = ctl_q.fetch & mem_ready;
    assign bus.pc_write    = (ctl_q.fetch & mem_ready) | (pcs & cond_ex & ~no_write);
    assign bus.reg_write   = ctl_q.reg_w & cond_ex & ~no_write;
    assign bus.mem_write   = ctl_q.mem_w & cond_ex;
    assign bus.adr_src     = ctl_q.adr_src;
    assign bus.result_src  = ctl_q.result_src;
    assign bus.alu_src_a   = ctl_q.alu_src_a;
    assign bus.alu_src_b   = ctl_q.alu_src_b;
    assign bus.alu_control = ctl_q.alu_control;
    assign bus.imm_src     = bus.op;
    assign bus.reg_src     = {(bus.op == 2'b01) & ~bus.funct[0], bus.op == 2'b10};
    assign bus.state       = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control; each task walks one instruction scenario.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    multicycle_control_if bus();

    multicycle_control #(.FLAGS_INIT(4'b0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r, input logic [3:0] c);
        bus.op = o; bus.funct = f; bus.rd = r; bus.cond = c;
        #1;
    endtask

    task automatic test_reset();
        bus.alu_flags = 4'b0000;
`ifdef MEM_WAIT_EN
        bus.mem_ready = 1'b1;
`endif
        set_instr(2'b11, 6'b000000, 4'd0, 4'hE);
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.state !== 4'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", bus.state); end
        n_cmp++;
        if ({bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_strobes: got %b want 0000", {bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write});
        end
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.ir_write !== 1'b0) begin n_bad++; $display("FAIL release_ir: got %b want 0", bus.ir_write); end
        @(negedge clk);
        n_cmp++; if (bus.state !== 4'd0) begin n_bad++; $display("FAIL first_fetch_state: got %0d want 0", bus.state); end
        n_cmp++; if (bus.ir_write !== 1'b1) begin n_bad++; $display("FAIL first_fetch_ir: got %b want 1", bus.ir_write); end
        n_cmp++; if (bus.pc_write !== 1'b1) begin n_bad++; $display("FAIL first_fetch_pc: got %b want 1", bus.pc_write); end
    endtask

    task automatic test_add();
        logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd6, 4'd8};
        logic       exp_rw [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        set_instr(2'b00, 6'b001000, 4'd1, 4'hE);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            n_cmp++; if (bus.state !== exp_st[i]) begin n_bad++; $display("FAIL add_state[%0d]: got %0d want %0d", i, bus.state, exp_st[i]); end
            n_cmp++; if (bus.reg_write !== exp_rw[i]) begin n_bad++; $display("FAIL add_reg_write[%0d]: got %b want %b", i, bus.reg_write, exp_rw[i]); end
            if (i == 2) begin
                n_cmp++; if (bus.alu_control !== 2'b00) begin n_bad++; $display("FAIL add_alu_control: got %b want 00", bus.alu_control); end
            end
            if (i == 3) begin
                n_cmp++; if (bus.pc_write !== 1'b0) begin n_bad++; $display("FAIL add_pc_write: got %b want 0", bus.pc_write); end
            end
        end
        @(negedge clk);
        n_cmp++; if (bus.state !== 4'd0) begin n_bad++; $display("FAIL add_return: got %0d want 0", bus.state); end
    endtask

    task automatic test_subs_beq();
        logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd7, 4'd8};
        set_instr(2'b00, 6'b100101, 4'd0, 4'hE);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            n_cmp++; if (bus.state !== exp_st[i]) begin n_bad++; $display("FAIL subs_state[%0d]: got %0d want %0d", i, bus.state, exp_st[i]); end
            if (i == 2) begin
                bus.alu_flags = 4'b0100;
                n_cmp++; if (bus.alu_control !== 2'b01) begin n_bad++; $display("FAIL subs_alu_control: got %b want 01", bus.alu_control); end
                n_cmp++; if (bus.alu_src_b !== 2'b01) begin n_bad++; $display("FAIL subs_alu_src_b: got %b want 01", bus.alu_src_b); end
            end
            if (i == 3) begin
                bus.alu_flags = 4'b0000;
                n_cmp++; if (bus.reg_write !== 1'b1) begin n_bad++; $display("FAIL subs_reg_write: got %b want 1", bus.reg_write); end
            end
        end
        @(negedge clk);
        set_instr(2'b10, 6'b100000, 4'd0, 4'h0);
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.state !== 4'd9) begin n_bad++; $display("FAIL beq_state: got %0d want 9", bus.state); end
        n_cmp++; if (bus.pc_write !== 1'b1) begin n_bad++; $display("FAIL beq_pc_write: got %b want 1", bus.pc_write); end
        n_cmp++; if (bus.imm_src !== 2'b10) begin n_bad++; $display("FAIL beq_imm_src: got %b want 10", bus.imm_src); end
        n_cmp++; if (bus.reg_src !== 2'b01) begin n_bad++; $display("FAIL beq_reg_src: got %b want 01", bus.reg_src); end
        n_cmp++; if (bus.result_src !== 2'b10) begin n_bad++; $display("FAIL beq_result_src: got %b want 10", bus.result_src); end
        @(negedge clk);
    endtask

    task automatic test_bne();
        set_instr(2'b10, 6'b100000, 4'd0, 4'h1);
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.state !== 4'd9) begin n_bad++; $display("FAIL bne_state: got %0d want 9", bus.state); end
        n_cmp++; if (bus.pc_write !== 1'b0) begin n_bad++; $display("FAIL bne_pc_write: got %b want 0", bus.pc_write); end
        @(negedge clk);
        n_cmp++; if (bus.state !== 4'd0) begin n_bad++; $display("FAIL bne_return: got %0d want 0", bus.state); end
        set_instr(2'b10, 6'b100000, 4'd0, 4'h0);
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.pc_write !== 1'b1) begin n_bad++; $display("FAIL bne_flags_kept: got %b want 1", bus.pc_write); end
        @(negedge clk);
    endtask

    task automatic test_ldr_str();
        logic [3:0] ld_st [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        logic [3:0] st_st [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
        set_instr(2'b01, 6'b011001, 4'd2, 4'hE);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            n_cmp++; if (bus.state !== ld_st[i]) begin n_bad++; $display("FAIL ldr_state[%0d]: got %0d want %0d", i, bus.state, ld_st[i]); end
            if (i == 2) begin
                n_cmp++; if ({bus.alu_src_b, bus.alu_control} !== 4'b0100) begin n_bad++; $display("FAIL ldr_memadr: got %b want 0100", {bus.alu_src_b, bus.alu_control}); end
            end
            if (i == 3) begin
                n_cmp++; if (bus.adr_src !== 1'b1) begin n_bad++; $display("FAIL ldr_adr_src: got %b want 1", bus.adr_src); end
            end
            if (i == 4) begin
                n_cmp++; if ({bus.result_src, bus.reg_write} !== 3'b011) begin n_bad++; $display("FAIL ldr_wb: got %b want 011", {bus.result_src, bus.reg_write}); end
            end
        end
        @(negedge clk);
        set_instr(2'b01, 6'b011000, 4'd3, 4'hE);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            n_cmp++; if (bus.state !== st_st[i]) begin n_bad++; $display("FAIL str_state[%0d]: got %0d want %0d", i, bus.state, st_st[i]); end
            n_cmp++; if (bus.mem_write !== (i == 3)) begin n_bad++; $display("FAIL str_mem_write[%0d]: got %b want %b", i, bus.mem_write, i == 3); end
            if (i == 3) begin
                n_cmp++; if ({bus.reg_src, bus.adr_src} !== 3'b101) begin n_bad++; $display("FAIL str_memwr: got %b want 101", {bus.reg_src, bus.adr_src}); end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_cmp();
        set_instr(2'b00, 6'b010101, 4'd0, 4'hE);
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.state !== 4'd6) begin n_bad++; $display("FAIL cmp_state: got %0d want 6", bus.state); end
        n_cmp++; if (bus.alu_control !== 2'b01) begin n_bad++; $display("FAIL cmp_alu_control: got %b want 01", bus.alu_control); end
        bus.alu_flags = 4'b1010;
        @(negedge clk);
        bus.alu_flags = 4'b0000;
        n_cmp++; if (bus.state !== 4'd8) begin n_bad++; $display("FAIL cmp_aluwb_state: got %0d want 8", bus.state); end
        n_cmp++; if ({bus.reg_write, bus.pc_write} !== 2'b00) begin n_bad++; $display("FAIL cmp_no_write: got %b want 00", {bus.reg_write, bus.pc_write}); end
        @(negedge clk);
    endtask

    // Flags are N=1 Z=0 C=1 V=0 here; each STR probes one condition code via mem_write.
    task automatic test_cond();
        logic [3:0] conds [13] = '{4'h4, 4'h5, 4'h0, 4'h1, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'h6, 4'h2, 4'hF};
        logic       exp_mw [13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 13; i++) begin
            set_instr(2'b01, 6'b011000, 4'd0, conds[i]);
            repeat (3) @(negedge clk);
            n_cmp++; if (bus.state !== 4'd5) begin n_bad++; $display("FAIL cond_state[%h]: got %0d want 5", conds[i], bus.state); end
            n_cmp++; if (bus.mem_write !== exp_mw[i]) begin n_bad++; $display("FAIL cond_mem_write[%h]: got %b want %b", conds[i], bus.mem_write, exp_mw[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_pc_rd15();
        logic [3:0] conds [2] = '{4'hE, 4'h0};
        logic [1:0] exp_w [2] = '{2'b11, 2'b00};
        for (int i = 0; i < 2; i++) begin
            set_instr(2'b00, 6'b001000, 4'hF, conds[i]);
            repeat (3) @(negedge clk);
            n_cmp++; if (bus.state !== 4'd8) begin n_bad++; $display("FAIL rd15_state[%0d]: got %0d want 8", i, bus.state); end
            n_cmp++; if ({bus.pc_write, bus.reg_write} !== exp_w[i]) begin n_bad++; $display("FAIL rd15_writes[%0d]: got %b want %b", i, {bus.pc_write, bus.reg_write}, exp_w[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        set_instr(2'b01, 6'b011000, 4'd0, 4'hE);
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.mem_write !== 1'b1) begin n_bad++; $display("FAIL mid_pre_mem_write: got %b want 1", bus.mem_write); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (bus.mem_write !== 1'b0) begin n_bad++; $display("FAIL mid_mem_write: got %b want 0", bus.mem_write); end
        n_cmp++; if (bus.state !== 4'd0) begin n_bad++; $display("FAIL mid_state: got %0d want 0", bus.state); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.ir_write !== 1'b0) begin n_bad++; $display("FAIL mid_release_ir: got %b want 0", bus.ir_write); end
        @(negedge clk);
        n_cmp++; if ({bus.state, bus.ir_write} !== 5'b00001) begin n_bad++; $display("FAIL mid_refetch: got %b want 00001", {bus.state, bus.ir_write}); end
        set_instr(2'b01, 6'b011000, 4'd0, 4'h4);
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.mem_write !== 1'b0) begin n_bad++; $display("FAIL mid_flags_init: got %b want 0", bus.mem_write); end
        @(negedge clk);
    endtask

`ifdef MEM_WAIT_EN
    task automatic test_mem_wait();
        set_instr(2'b11, 6'b000000, 4'd0, 4'hE);
        bus.mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if ({bus.state, bus.ir_write} !== 5'b00000) begin n_bad++; $display("FAIL wait_hold[%0d]: got %b want 00000", k, {bus.state, bus.ir_write}); end
            @(negedge clk);
        end
        bus.mem_ready = 1'b1;
        #1;
        n_cmp++; if (bus.ir_write !== 1'b1) begin n_bad++; $display("FAIL wait_ir: got %b want 1", bus.ir_write); end
        @(negedge clk);
        n_cmp++; if (bus.state !== 4'd1) begin n_bad++; $display("FAIL wait_decode: got %0d want 1", bus.state); end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_subs_beq();
        test_bne();
        test_ldr_str();
        test_cmp();
        test_cond();
        test_pc_rd15();
        test_reset_mid();
`ifdef MEM_WAIT_EN
        test_mem_wait();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
